if_fetch_unit: RTL and testbench

- Instruction-fetch initiator: owns the PC, drives the instruction ROM's chip-enable and address, and registers the returned word into the IF/ID pipeline register.
- Sits between the combinational instruction ROM (word returned in the same cycle as the address) and the decode stage.
- Handles stalls, branch redirects with MIPS delay-slot semantics, pipeline flush to an exception/restart vector, and misaligned-fetch detection.

---
 rtl/if_fetch_unit_if.sv | 9 +
 rtl/if_fetch_unit.sv | 80 ++++++++
 tb/tb_if_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction ROM fetch bus between fetch unit and ROM
interface if_fetch_unit_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  modport master (output rom_ce, output rom_addr, input rom_inst);
  modport slave  (input rom_ce, input rom_addr, output rom_inst);
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner, ROM fetch driver and IF/ID pipeline register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_unit_if.master        rom,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   branch_flag,
  input  logic [31:0]            branch_target,
  input  logic                   flush,
  input  logic [31:0]            new_pc,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_inst,
  output logic                   id_valid,
  output logic                   id_fetch_err
);

  logic        ce_q;
  logic [31:0] pc_q;
  logic        misaligned;

  assign rom.rom_ce   = ce_q;
  assign rom.rom_addr = pc_q;
  assign misaligned   = (pc_q[1:0] != 2'b00);

  // A branch arriving with stall_if is dropped; ID re-presents it after the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= 1'b1;
      if (ce_q) begin
        if (flush) begin
          pc_q <= new_pc;
        end else if (!stall_if) begin
          if (branch_flag) begin
            pc_q <= branch_target;
          end else begin
            pc_q <= pc_q + PC_STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc        <= 32'h0;
      id_inst      <= 32'h0;
      id_valid     <= 1'b0;
      id_fetch_err <= 1'b0;
    end else if (flush) begin
      id_pc        <= 32'h0;
      id_inst      <= 32'h0;
      id_valid     <= 1'b0;
      id_fetch_err <= 1'b0;
    end else if (stall_if && stall_id) begin
      id_pc        <= id_pc;
      id_inst      <= id_inst;
      id_valid     <= id_valid;
      id_fetch_err <= id_fetch_err;
    end else if (stall_if || !ce_q) begin
      id_pc        <= 32'h0;
      id_inst      <= 32'h0;
      id_valid     <= 1'b0;
      id_fetch_err <= 1'b0;
    end else begin
      // Misaligned words are tagged, not executed; the exception path flushes later.
      id_pc        <= pc_q;
      id_inst      <= misaligned ? 32'h0 : rom.rom_inst;
      id_valid     <= 1'b1;
      id_fetch_err <= misaligned;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed plus randomized bench for if_fetch_unit
module tb_if_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_fetch_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state: what the fetch unit should hold, derived from the rules.
  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic        m_valid;
  logic        m_err;

  if_fetch_unit_if rom ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom           (rom.master),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .id_fetch_err  (id_fetch_err)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign rom.rom_inst = rom.rom_ce ? rom_word(rom.rom_addr) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ce"},    {31'b0, rom.rom_ce}, {31'b0, m_ce});
    chk({tag, ".addr"},  rom.rom_addr,        m_pc);
    chk({tag, ".idpc"},  id_pc,               m_idpc);
    chk({tag, ".inst"},  id_inst,             m_idinst);
    chk({tag, ".valid"}, {31'b0, id_valid},   {31'b0, m_valid});
    chk({tag, ".err"},   {31'b0, id_fetch_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    m_ce = 1'b0; m_pc = 32'h0;
    m_idpc = 32'h0; m_idinst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic step(input string tag, input logic si, input logic sid, input logic br,
                      input logic [31:0] bt, input logic fl, input logic [31:0] np);
    logic [31:0] fpc;
    logic        fetching;
    stall_if = si; stall_id = sid; branch_flag = br; branch_target = bt;
    flush = fl; new_pc = np;
    fpc = m_pc;
    fetching = m_ce;
    @(posedge clk);
    if (fl) begin
      m_idpc = 0; m_idinst = 0; m_valid = 0; m_err = 0;
    end else if (si && sid) begin
      m_idpc = m_idpc;
    end else if (si || !fetching) begin
      m_idpc = 0; m_idinst = 0; m_valid = 0; m_err = 0;
    end else begin
      m_idpc  = fpc;
      m_valid = 1'b1;
      m_err   = (fpc % 4) != 0;
      m_idinst = m_err ? 32'h0 : rom_word(fpc);
    end
    if (fetching) begin
      if (fl) m_pc = np;
      else if (!si) m_pc = br ? bt : fpc + 32'd4;
    end
    m_ce = 1'b1;
    #1;
    chk_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_if = 0; stall_id = 0; branch_flag = 0; branch_target = 0; flush = 0; new_pc = 0;
    model_reset();
    #2;
    chk_model("reset");
    rst_n = 1'b1;

    step("edge1", 0, 0, 0, 0, 0, 0);
    chk("ce_rise", {31'b0, rom.rom_ce}, 32'd1);
    step("edge2", 0, 0, 0, 0, 0, 0);
    chk("first_pc", id_pc, 32'h0);
    chk("first_inst", id_inst, 32'h1000_0000);
    step("seq4", 0, 0, 0, 0, 0, 0);
    chk("seq_pc4", id_pc, 32'h4);
    step("br", 0, 0, 1, 32'h40, 0, 0);
    chk("delay_slot", id_pc, 32'h8);
    step("br_tgt", 0, 0, 0, 0, 0, 0);
    chk("br_tgt_pc", id_pc, 32'h40);
    chk("br_tgt_inst", id_inst, 32'h1000_0010);

    step("stall1", 1, 0, 0, 0, 0, 0);
    step("stall2", 1, 0, 0, 0, 0, 0);
    chk("stall_hold", rom.rom_addr, 32'h44);
    step("unstall", 0, 0, 0, 0, 0, 0);
    step("pre_freeze", 0, 0, 0, 0, 0, 0);
    step("freeze1", 1, 1, 0, 0, 0, 0);
    step("freeze2", 1, 1, 0, 0, 0, 0);
    chk("freeze_pc", id_pc, 32'h48);

    step("flush_prio", 1, 0, 1, 32'h300, 1, 32'h180);
    chk("flush_addr", rom.rom_addr, 32'h180);
    step("after_flush", 0, 0, 0, 0, 0, 0);
    chk("flush_idpc", id_pc, 32'h180);

    step("br_mis", 0, 0, 1, 32'h22, 0, 0);
    step("mis", 0, 0, 0, 0, 0, 0);
    chk("mis_pc", id_pc, 32'h22);
    chk("mis_err", {31'b0, id_fetch_err}, 32'd1);
    step("flush_top", 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("top", 0, 0, 0, 0, 0, 0);
    chk("wrap", rom.rom_addr, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic si, sid, br, fl;
      logic [31:0] bt, np;
      si  = ($urandom % 4) == 0;
      sid = $urandom % 2;
      br  = ($urandom % 6) == 0;
      fl  = ($urandom % 12) == 0;
      bt  = ($urandom_range(0, 1023) << 2) | ((($urandom % 8) == 0) ? ($urandom % 4) : 0);
      np  = ($urandom % 5 == 0) ? (32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2))
                                : ($urandom_range(0, 1023) << 2);
      step("rand", si, sid, br, bt, fl, np);
    end

    step("pre_rst", 0, 0, 0, 0, 0, 0);
    stall_if = 1'b1; stall_id = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("async_rst");
    #2;
    rst_n = 1'b1;
    step("re_edge1", 0, 0, 0, 0, 0, 0);
    chk("re_ce", {31'b0, rom.rom_ce}, 32'd1);
    step("re_edge2", 0, 0, 0, 0, 0, 0);
    chk("re_valid", {31'b0, id_valid}, 32'd1);
    chk("re_inst", id_inst, 32'h1000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
